// File: rtl/io_pkg.sv
// Shared address map, select encoding and decode helper for the miniRV I/O bridge.
package io_pkg;

  localparam logic [19:0] PERIPH_BASE  = 20'hFFFFF;
  localparam logic [11:0] OFF_DIG      = 12'h000;
  localparam logic [11:0] OFF_LED      = 12'h060;
  localparam logic [11:0] OFF_SW       = 12'h070;
  localparam logic [11:0] OFF_BTN      = 12'h078;
  localparam logic [11:0] OFF_BTN_EDGE = 12'h07C;

  localparam int DEBOUNCE_DEFAULT = 100000;

  typedef enum logic [2:0] {
    SEL_DRAM,
    SEL_DIG,
    SEL_LED,
    SEL_SW,
    SEL_BTN,
    SEL_BTN_EDGE,
    SEL_NONE
  } periph_sel_e;

  function automatic periph_sel_e decode_addr(input logic [31:0] addr);
    if (addr[31:12] != PERIPH_BASE) return SEL_DRAM;
    case (addr[11:0])
      OFF_DIG:      return SEL_DIG;
      OFF_LED:      return SEL_LED;
      OFF_SW:       return SEL_SW;
      OFF_BTN:      return SEL_BTN;
      OFF_BTN_EDGE: return SEL_BTN_EDGE;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer; a level is accepted once it is
// seen identically at two consecutive ticks. rise flags the edge at which db goes 0->1.
module io_debounce #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] samp;
  logic [W-1:0] agree;

  assign agree = ~(sync2 ^ samp);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      samp  <= '0;
      db    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        samp <= sync2;
        db   <= (db & ~agree) | (sync2 & agree);
      end
    end
  end

  assign rise = {W{tick}} & agree & sync2 & ~db;

endmodule

// File: rtl/io_bridge.sv
// Address-decoding bridge between the miniRV data port and RAM, display, LEDs, switches, buttons.
// Optional sticky button-edge register at 0x07C is enabled by defining IO_BRIDGE_BTN_EDGE_EN.
module io_bridge
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int TICK_W          = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  output logic [11:0] dig_addr,
  output logic        dig_wen,
  output logic [31:0] dig_wdata,
  output logic [23:0] led,
  input  logic [23:0] sw,
  input  logic [4:0]  btn
);

  periph_sel_e       sel;
  logic [TICK_W-1:0] count;
  logic              tick;
  logic [23:0]       sw_db;
  logic [23:0]       sw_rise_unused;
  logic [4:0]        btn_db;
  logic [4:0]        btn_rise;

  assign sel        = decode_addr(cpu_addr);
  assign dram_we    = cpu_we & (sel == SEL_DRAM);
  assign dig_wen    = cpu_we & (sel == SEL_DIG);
  assign dram_addr  = cpu_addr;
  assign dram_wdata = cpu_wdata;
  assign dig_addr   = cpu_addr[11:0];
  assign dig_wdata  = cpu_wdata;

  // One shared tick keeps both debouncers sampling in lockstep.
  assign tick = (count == TICK_W'(DEBOUNCE_CYCLES - 1));

  // NOTE: asynchronous reset belongs in the sensitivity list; the rst branch must come first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (tick) count <= '0;
    else           count <= count + TICK_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             led <= '0;
    else if (cpu_we && sel == SEL_LED)   led <= cpu_wdata[23:0];
  end

  io_debounce #(.W(24)) u_sw_db (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .raw  (sw),
    .db   (sw_db),
    .rise (sw_rise_unused)
  );

  io_debounce #(.W(5)) u_btn_db (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .raw  (btn),
    .db   (btn_db),
    .rise (btn_rise)
  );

`ifdef IO_BRIDGE_BTN_EDGE_EN
  logic [4:0] btn_edge;
  logic [4:0] edge_clr;

  assign edge_clr = (cpu_we && sel == SEL_BTN_EDGE) ? cpu_wdata[4:0] : 5'b0;

  // Set is ORed in after the clear so a coincident rise wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_edge <= '0;
    else     btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
  end
`else
  logic unused_btn_rise;
  assign unused_btn_rise = ^btn_rise;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cpu_rdata = 32'b0;
    case (sel)
      SEL_DRAM:     cpu_rdata = dram_rdata;
      SEL_LED:      cpu_rdata = {8'b0, led};
      SEL_SW:       cpu_rdata = {8'b0, sw_db};
      SEL_BTN:      cpu_rdata = {27'b0, btn_db};
`ifdef IO_BRIDGE_BTN_EDGE_EN
      SEL_BTN_EDGE: cpu_rdata = {27'b0, btn_edge};
`endif
      default:      cpu_rdata = 32'b0;
    endcase
  end

endmodule
